reg_read_stage: RTL

// Register-read stage: producer side of the reg-read -> execute handshake.

---
 rtl/reg_read_stage_pkg.sv | 46 ++++
 rtl/reg_read_stage_skid_buf.sv | 80 ++++++++
 rtl/reg_read_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/reg_read_stage_pkg.sv
// Shared backend definitions for the register-read stage: widths, the exec
// packet handed to execute, the skid-buffer occupancy states and the operand
// select helper.
package reg_read_stage_pkg;

  localparam int unsigned PREG_W = 6;
  localparam int unsigned ROB_W  = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned XLEN   = 32;

  typedef struct packed {
    logic              alu_en;
    logic [OPC_W-1:0]  opcode;
    logic [XLEN-1:0]   src1_val;
    logic [XLEN-1:0]   src2_val;
    logic [PREG_W-1:0] dst_preg;
    logic [ROB_W-1:0]  rob_idx;
  } exec_packet_t;

  // Occupancy of the out + skid register pair.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

  // Operand priority: hardwired zero register, then same-cycle bypass, then regfile.
  function automatic logic [XLEN-1:0] select_operand(
    input logic [PREG_W-1:0] preg,
    input logic [XLEN-1:0]   rf_data,
    input logic              fwd_valid,
    input logic [PREG_W-1:0] fwd_preg,
    input logic [XLEN-1:0]   fwd_data
  );
    logic [XLEN-1:0] val;
    if (preg == '0) begin
      val = '0;
    end else if (fwd_valid && (fwd_preg == preg)) begin
      val = fwd_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

endpackage

// File: rtl/reg_read_stage_skid_buf.sv
// Two-register (out + skid) valid/ready buffer of exec packets. The upstream
// ready comes straight from a register so it never depends on downstream ready.
// A flush empties both registers on the next edge.
module reg_read_stage_skid_buf
  import reg_read_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  exec_packet_t in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output exec_packet_t out_data_o
);

  buf_state_e   state_q, state_d;
  exec_packet_t out_q, out_d;
  exec_packet_t skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  assign out_valid_o = (state_q != StEmpty);
  assign in_ready_o  = (state_q != StFull) && !rst;
  assign out_data_o  = out_q;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  // Next occupancy and payload moves; flush overrides everything.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            out_d   = in_data_i;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            out_d = in_data_i;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            out_d   = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: reads both sources of an issued micro-op from the
// register file, applies the execute-result bypass, and hands a complete exec
// packet to execute through a registered-ready skid buffer.
module reg_read_stage
  import reg_read_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              iss_alu_en,
  input  logic [OPC_W-1:0]  iss_opcode,
  input  logic [PREG_W-1:0] iss_src1_preg,
  input  logic [PREG_W-1:0] iss_src2_preg,
  input  logic              iss_use_imm,
  input  logic [XLEN-1:0]   iss_imm,
  input  logic [PREG_W-1:0] iss_dst_preg,
  input  logic [ROB_W-1:0]  iss_rob_idx,
  output logic [PREG_W-1:0] rf_rd1_addr,
  input  logic [XLEN-1:0]   rf_rd1_data,
  output logic [PREG_W-1:0] rf_rd2_addr,
  input  logic [XLEN-1:0]   rf_rd2_data,
  input  logic              fwd_valid,
  input  logic [PREG_W-1:0] fwd_preg,
  input  logic [XLEN-1:0]   fwd_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic              ex_alu_en,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [XLEN-1:0]   ex_src1_val,
  output logic [XLEN-1:0]   ex_src2_val,
  output logic [PREG_W-1:0] ex_dst_preg,
  output logic [ROB_W-1:0]  ex_rob_idx,
  output logic [XLEN-1:0]   perf_stall_cnt
);

  exec_packet_t iss_pkt;
  exec_packet_t ex_pkt;
  logic [XLEN-1:0] perf_q, perf_d;

  assign rf_rd1_addr = iss_src1_preg;
  assign rf_rd2_addr = iss_src2_preg;

  // Build the packet from the current issue; operands are frozen once captured.
  always_comb begin
    iss_pkt          = '0;
    iss_pkt.alu_en   = iss_alu_en;
    iss_pkt.opcode   = iss_opcode;
    iss_pkt.src1_val = select_operand(iss_src1_preg, rf_rd1_data, fwd_valid, fwd_preg, fwd_data);
    iss_pkt.src2_val = iss_use_imm ? iss_imm :
                       select_operand(iss_src2_preg, rf_rd2_data, fwd_valid, fwd_preg, fwd_data);
    iss_pkt.dst_preg = iss_dst_preg;
    iss_pkt.rob_idx  = iss_rob_idx;
  end

  reg_read_stage_skid_buf u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (iss_valid),
    .in_ready_o  (iss_ready),
    .in_data_i   (iss_pkt),
    .out_valid_o (ex_valid),
    .out_ready_i (ex_ready),
    .out_data_o  (ex_pkt)
  );

  assign ex_alu_en   = ex_pkt.alu_en;
  assign ex_opcode   = ex_pkt.opcode;
  assign ex_src1_val = ex_pkt.src1_val;
  assign ex_src2_val = ex_pkt.src2_val;
  assign ex_dst_preg = ex_pkt.dst_preg;
  assign ex_rob_idx  = ex_pkt.rob_idx;

  // Stall counter saturates instead of wrapping; flush does not touch it.
  always_comb begin
    perf_d = perf_q;
    if (ex_valid && !ex_ready && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;

endmodule
